dc_frame_dispatcher: RTL and testbench

- Parametrised successor to the DC frame/launch dispatcher.
- Drains a first-word-fall-through 32-bit command FIFO and classifies each packet by its header word: DC-register frame, or launch command.
- Payloads are assembled in a staging buffer and committed atomically to double-buffered outputs for the DAC update and launch logic.
- Adds header validation, stall timeout with abort, an explicit discard path, and frame/error counters.

---
 rtl/dc_dispatch_pkg.sv | 18 +
 rtl/dc_hdr_decode.sv | 30 +++
 rtl/dc_frame_dispatcher.sv | 214 +++++++++++++++++++++
 tb/tb_dc_frame_dispatcher.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/dc_dispatch_pkg.sv
// Shared types, constants and helpers for the DC frame / launch dispatcher.
package dc_dispatch_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPayload,
    StLaunch,
    StDrain
  } state_t;

  localparam logic [31:0] LAUNCH_HDR  = 32'hFFFF_FFFF;
  localparam int unsigned CH_MASK_LSB = 8;

  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val == max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/dc_hdr_decode.sv
// Header word classifier: launch marker, or a channel mask with exactly one active-low bit.
module dc_hdr_decode
  import dc_dispatch_pkg::*;
#(
  parameter int unsigned DAC_CHANNEL = 24,
  localparam int unsigned CH_W = (DAC_CHANNEL > 1) ? $clog2(DAC_CHANNEL) : 1
) (
  input  logic [31:0]     hdr,
  output logic            is_launch,
  output logic            hdr_ok,
  output logic [CH_W-1:0] ch_idx
);

  logic [5:0] zeros;

  always_comb begin
    zeros  = '0;
    ch_idx = '0;
    for (int i = 0; i < DAC_CHANNEL; i++) begin
      if (!hdr[CH_MASK_LSB + i]) begin
        zeros  = zeros + 6'd1;
        ch_idx = CH_W'(i);
      end
    end
  end

  assign hdr_ok    = (zeros == 6'd1);
  assign is_launch = (hdr == LAUNCH_HDR);

endmodule

// File: rtl/dc_frame_dispatcher.sv
// Drains an FWFT command FIFO, stages DC frames / launch payloads and commits them atomically.
module dc_frame_dispatcher
  import dc_dispatch_pkg::*;
#(
  parameter int unsigned DAC_CHANNEL    = 24,
  parameter int unsigned FRAME_WORDS    = 62,
  parameter int unsigned LAUNCH_WORDS   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 16,
  localparam int unsigned CH_W = (DAC_CHANNEL > 1) ? $clog2(DAC_CHANNEL) : 1
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic [31:0]                       i_fifo_data,
  input  logic                              i_fifo_empty,
  output logic                              o_fifo_deq,
  output logic [FRAME_WORDS-1:0][31:0]      o_dc_regs,
  output logic [CH_W-1:0]                   o_channel_sel,
  output logic                              o_valid_frame,
  output logic [LAUNCH_WORDS-1:0][31:0]     o_launch_cmd,
  output logic                              o_launch_valid,
  output logic                              o_err_hdr,
  output logic                              o_err_timeout,
  output logic [CNT_W-1:0]                  o_frame_cnt,
  output logic [CNT_W-1:0]                  o_err_cnt
);

  localparam int unsigned MAX_WORDS = (FRAME_WORDS > LAUNCH_WORDS) ? FRAME_WORDS : LAUNCH_WORDS;
  localparam int unsigned CNT_IW    = $clog2(MAX_WORDS);
  localparam int unsigned STALL_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [31:0] ERR_MAX   = 32'({CNT_W{1'b1}});

  state_t                          state_q, state_d;
  logic [CNT_IW-1:0]               cnt_q, cnt_d;
  logic [STALL_W-1:0]              stall_q, stall_d;
  logic [FRAME_WORDS-1:0][31:0]    staging_q, staging_d;
  logic [LAUNCH_WORDS-1:0][31:0]   launch_stg_q, launch_stg_d;
  logic [CH_W-1:0]                 pend_ch_q, pend_ch_d;
  logic [FRAME_WORDS-1:0][31:0]    dc_regs_q, dc_regs_d;
  logic [CH_W-1:0]                 ch_sel_q, ch_sel_d;
  logic [LAUNCH_WORDS-1:0][31:0]   launch_cmd_q, launch_cmd_d;
  logic                            valid_frame_q, valid_frame_d;
  logic                            launch_valid_q, launch_valid_d;
  logic                            err_hdr_q, err_hdr_d;
  logic                            err_tmo_q, err_tmo_d;
  logic [CNT_W-1:0]                frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]                err_cnt_q, err_cnt_d;

  logic            pop;
  logic            is_launch;
  logic            hdr_ok;
  logic [CH_W-1:0] hdr_ch;
  logic            stall_hit;
  logic            last_frame;
  logic            last_launch;

  dc_hdr_decode #(
    .DAC_CHANNEL (DAC_CHANNEL)
  ) u_hdr_decode (
    .hdr       (i_fifo_data),
    .is_launch (is_launch),
    .hdr_ok    (hdr_ok),
    .ch_idx    (hdr_ch)
  );

  assign pop         = !i_fifo_empty;
  assign o_fifo_deq  = pop;
  assign last_frame  = (cnt_q == CNT_IW'(FRAME_WORDS - 1));
  assign last_launch = (cnt_q == CNT_IW'(LAUNCH_WORDS - 1));
  // Abort on the empty cycle that would bring the stall count to TIMEOUT_CYCLES.
  assign stall_hit   = (TIMEOUT_CYCLES != 0) && (state_q != StIdle) && !pop &&
                       (stall_q == STALL_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          if (is_launch)   state_d = StLaunch;
          else if (hdr_ok) state_d = StPayload;
          else             state_d = StDrain;
        end
      end
      StPayload, StDrain: begin
        if (stall_hit || (pop && last_frame)) state_d = StIdle;
      end
      StLaunch: begin
        if (stall_hit || (pop && last_launch)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d          = cnt_q;
    stall_d        = '0;
    staging_d      = staging_q;
    launch_stg_d   = launch_stg_q;
    pend_ch_d      = pend_ch_q;
    dc_regs_d      = dc_regs_q;
    ch_sel_d       = ch_sel_q;
    launch_cmd_d   = launch_cmd_q;
    valid_frame_d  = 1'b0;
    launch_valid_d = 1'b0;
    err_hdr_d      = 1'b0;
    err_tmo_d      = 1'b0;
    frame_cnt_d    = frame_cnt_q;
    err_cnt_d      = err_cnt_q;

    if (state_q != StIdle && !pop && TIMEOUT_CYCLES != 0 && !stall_hit) begin
      stall_d = stall_q + STALL_W'(1);
    end

    if (stall_hit) begin
      err_tmo_d = 1'b1;
      err_cnt_d = CNT_W'(sat_inc(32'(err_cnt_q), ERR_MAX));
    end else if (pop) begin
      unique case (state_q)
        StIdle: begin
          if (is_launch) begin
            cnt_d = '0;
          end else if (hdr_ok) begin
            staging_d[0] = i_fifo_data;
            pend_ch_d    = hdr_ch;
            cnt_d        = CNT_IW'(1);
          end else begin
            err_hdr_d = 1'b1;
            err_cnt_d = CNT_W'(sat_inc(32'(err_cnt_q), ERR_MAX));
            cnt_d     = CNT_IW'(1);
          end
        end
        StPayload: begin
          for (int i = 0; i < FRAME_WORDS; i++) begin
            if (cnt_q == CNT_IW'(i)) staging_d[i] = i_fifo_data;
          end
          cnt_d = cnt_q + CNT_IW'(1);
          if (last_frame) begin
            dc_regs_d     = staging_d;
            ch_sel_d      = pend_ch_q;
            valid_frame_d = 1'b1;
            frame_cnt_d   = frame_cnt_q + CNT_W'(1);
          end
        end
        StLaunch: begin
          for (int i = 0; i < LAUNCH_WORDS; i++) begin
            if (cnt_q == CNT_IW'(i)) launch_stg_d[i] = i_fifo_data;
          end
          cnt_d = cnt_q + CNT_IW'(1);
          if (last_launch) begin
            launch_cmd_d   = launch_stg_d;
            launch_valid_d = 1'b1;
          end
        end
        StDrain: begin
          cnt_d = cnt_q + CNT_IW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q          <= '0;
      stall_q        <= '0;
      staging_q      <= '0;
      launch_stg_q   <= '0;
      pend_ch_q      <= '0;
      dc_regs_q      <= '0;
      ch_sel_q       <= '0;
      launch_cmd_q   <= '0;
      valid_frame_q  <= 1'b0;
      launch_valid_q <= 1'b0;
      err_hdr_q      <= 1'b0;
      err_tmo_q      <= 1'b0;
      frame_cnt_q    <= '0;
      err_cnt_q      <= '0;
    end else begin
      cnt_q          <= cnt_d;
      stall_q        <= stall_d;
      staging_q      <= staging_d;
      launch_stg_q   <= launch_stg_d;
      pend_ch_q      <= pend_ch_d;
      dc_regs_q      <= dc_regs_d;
      ch_sel_q       <= ch_sel_d;
      launch_cmd_q   <= launch_cmd_d;
      valid_frame_q  <= valid_frame_d;
      launch_valid_q <= launch_valid_d;
      err_hdr_q      <= err_hdr_d;
      err_tmo_q      <= err_tmo_d;
      frame_cnt_q    <= frame_cnt_d;
      err_cnt_q      <= err_cnt_d;
    end
  end

  assign o_dc_regs      = dc_regs_q;
  assign o_channel_sel  = ch_sel_q;
  assign o_valid_frame  = valid_frame_q;
  assign o_launch_cmd   = launch_cmd_q;
  assign o_launch_valid = launch_valid_q;
  assign o_err_hdr      = err_hdr_q;
  assign o_err_timeout  = err_tmo_q;
  assign o_frame_cnt    = frame_cnt_q;
  assign o_err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_dc_frame_dispatcher.sv
// Scoreboard bench: drivers push expected commit/error events, a negedge monitor checks them.
module tb_dc_frame_dispatcher;

  localparam int unsigned DC = 24;
  localparam int unsigned FW = 62;
  localparam int unsigned LW = 4;
  localparam int unsigned TO = 16;
  localparam int unsigned CW = 16;

  localparam int EvFrame  = 0;
  localparam int EvLaunch = 1;
  localparam int EvHdr    = 2;
  localparam int EvTmo    = 3;

  logic                  i_clk;
  logic                  i_rst_n;
  logic [31:0]           i_fifo_data;
  logic                  i_fifo_empty;
  logic                  o_fifo_deq;
  logic [FW-1:0][31:0]   o_dc_regs;
  logic [4:0]            o_channel_sel;
  logic                  o_valid_frame;
  logic [LW-1:0][31:0]   o_launch_cmd;
  logic                  o_launch_valid;
  logic                  o_err_hdr;
  logic                  o_err_timeout;
  logic [CW-1:0]         o_frame_cnt;
  logic [CW-1:0]         o_err_cnt;

  dc_frame_dispatcher #(
    .DAC_CHANNEL    (DC),
    .FRAME_WORDS    (FW),
    .LAUNCH_WORDS   (LW),
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (CW)
  ) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_fifo_data    (i_fifo_data),
    .i_fifo_empty   (i_fifo_empty),
    .o_fifo_deq     (o_fifo_deq),
    .o_dc_regs      (o_dc_regs),
    .o_channel_sel  (o_channel_sel),
    .o_valid_frame  (o_valid_frame),
    .o_launch_cmd   (o_launch_cmd),
    .o_launch_valid (o_launch_valid),
    .o_err_hdr      (o_err_hdr),
    .o_err_timeout  (o_err_timeout),
    .o_frame_cnt    (o_frame_cnt),
    .o_err_cnt      (o_err_cnt)
  );

  typedef struct {
    int             kind;
    int             cyc;
    logic [4:0]     ch;
    logic [31:0]    w0;
    logic [31:0]    w1;
    logic [31:0]    wl;
    logic [LW*32-1:0] lc;
    logic [CW-1:0]  fc;
    logic [CW-1:0]  ec;
  } ev_t;

  ev_t sb[$];

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int last_cyc;

  // Reference model of the committed outputs
  logic [4:0]       m_ch;
  logic [31:0]      m_w0, m_w1, m_wl;
  logic [LW*32-1:0] m_lc;
  logic [CW-1:0]    m_fc, m_ec;

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  always @(posedge i_clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic void push(int kind, int at);
    ev_t e;
    e.kind = kind; e.cyc = at; e.ch = m_ch; e.w0 = m_w0; e.w1 = m_w1; e.wl = m_wl;
    e.lc = m_lc; e.fc = m_fc; e.ec = m_ec;
    sb.push_back(e);
  endfunction

  function automatic void model_clear();
    m_ch = '0; m_w0 = '0; m_w1 = '0; m_wl = '0; m_lc = '0; m_fc = '0; m_ec = '0;
  endfunction

  task automatic put(input logic [31:0] w);
    i_fifo_data  = w;
    i_fifo_empty = 1'b0;
    last_cyc     = cyc + 1;
    @(posedge i_clk);
    #1;
  endtask

  task automatic gap(input int n);
    i_fifo_empty = 1'b1;
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic send_frame(input logic [31:0] hdr, input logic [4:0] ch, input int base,
                            input bit good);
    put(hdr);
    if (!good) begin
      m_ec = m_ec + 1'b1;
      push(EvHdr, last_cyc);
    end
    for (int i = 1; i < FW; i++) put(32'(base + i));
    if (good) begin
      m_ch = ch; m_w0 = hdr; m_w1 = 32'(base + 1); m_wl = 32'(base + FW - 1);
      m_fc = m_fc + 1'b1;
      push(EvFrame, last_cyc);
    end
  endtask

  task automatic send_launch(input logic [31:0] a, b, c, d);
    put(32'hFFFF_FFFF);
    put(a); put(b); put(c); put(d);
    m_lc = {d, c, b, a};
    push(EvLaunch, last_cyc);
  endtask

  always @(negedge i_clk) begin
    ev_t e;
    int  act_kind;
    chk("fifo_deq", o_fifo_deq, !i_fifo_empty);
    if (o_valid_frame || o_launch_valid || o_err_hdr || o_err_timeout) begin
      chk("event_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        act_kind = o_valid_frame ? EvFrame : o_launch_valid ? EvLaunch :
                   o_err_hdr ? EvHdr : EvTmo;
        chk("event_kind", act_kind, e.kind);
        chk("event_cycle", cyc, e.cyc);
        chk("channel_sel", o_channel_sel, e.ch);
        chk("dc_regs_w0", o_dc_regs[0], e.w0);
        chk("dc_regs_w1", o_dc_regs[1], e.w1);
        chk("dc_regs_last", o_dc_regs[FW-1], e.wl);
        chk("launch_cmd", o_launch_cmd, e.lc);
        chk("frame_cnt", o_frame_cnt, e.fc);
        chk("err_cnt", o_err_cnt, e.ec);
      end
    end
  end

  initial begin
    model_clear();
    i_rst_n      = 1'b0;
    i_fifo_empty = 1'b1;
    i_fifo_data  = '0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_dc_regs", |o_dc_regs, 0);
    chk("rst_launch_cmd", |o_launch_cmd, 0);
    chk("rst_pulses", {o_valid_frame, o_launch_valid, o_err_hdr, o_err_timeout}, 0);
    chk("rst_counters", {o_frame_cnt, o_err_cnt, o_channel_sel}, 0);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    send_frame(32'hFFFF_FBFF, 5'd2, 0, 1'b1);
    gap(3);
    send_launch(32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003, 32'hD0D0_0004);
    gap(2);
    send_frame(32'hFFFF_F3FF, 5'd0, 100, 1'b0);
    gap(1);
    send_frame(32'hFFFF_DFFF, 5'd5, 200, 1'b1);
    gap(2);

    // Stall mid-frame; a launch straight after the abort proves the FSM is back in idle
    put(32'hFFFF_FEFF);
    for (int i = 1; i <= 10; i++) put(32'(600 + i));
    m_ec = m_ec + 1'b1;
    push(EvTmo, cyc + TO);
    gap(TO);
    send_launch(32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444);
    gap(2);

    send_frame(32'h7FFF_FFFF, 5'd23, 300, 1'b1);
    send_launch(32'h5555_0001, 32'h5555_0002, 32'h5555_0003, 32'h5555_0004);
    send_frame(32'hFFFF_FDFF, 5'd1, 400, 1'b1);
    gap(3);

    // Asynchronous reset mid-payload, away from any clock edge
    put(32'hFFFF_FBFF);
    for (int i = 1; i <= 29; i++) put(32'(700 + i));
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("async_rst_frame_cnt", o_frame_cnt, 0);
    chk("async_rst_err_cnt", o_err_cnt, 0);
    chk("async_rst_dc_regs", |o_dc_regs, 0);
    chk("async_rst_launch", |o_launch_cmd, 0);
    chk("async_rst_ch", o_channel_sel, 0);
    i_fifo_empty = 1'b1;
    model_clear();
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    gap(1);
    send_frame(32'hFFFF_FBFF, 5'd2, 500, 1'b1);
    gap(4);

    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
